shift_rows_stage: RTL and testbench
===================================

SHIFT_ROWS_STAGE -- requirements
Module: shift_rows_stage

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns (legal 4, 6, 8); W = 32*NB.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning input block offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the stage accepts a block this cycle.
REQ-006 The block SHALL have port in_data, input, W, the state in column-major byte order: byte (r,c) at bits [W-1-8*(4c+r) -: 8].
REQ-007 The block SHALL have port in_inv, input, 1, selecting inverse shift (see Configuration).
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data holds a result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 The block SHALL have port out_data, output, W, the shifted state in the same byte order.
REQ-011 The block SHALL have port blk_count, output, 16, the count of completed output transfers.

Function
REQ-012 Row offsets s_r SHALL be {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-013 Forward mode SHALL give out(r,c) = in(r, (c+s_r) mod NB); inverse mode SHALL give out(r,c) = in(r, (c-s_r) mod NB).
REQ-014 The stage SHALL be a one-entry output register with FSM states EMPTY and FULL.
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (state==EMPTY) || out_ready, combinationally.
REQ-017 EMPTY->FULL on input transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL on simultaneous transfers, with the new result loaded.
REQ-018 Latency SHALL be exactly one cycle: a block accepted at edge N is visible on out_data with out_valid=1 after edge N.
REQ-019 Throughput SHALL be one block per cycle while out_ready is held high.
REQ-020 While FULL and out_ready=0, out_data and out_valid SHALL remain stable, and in_data/in_inv SHALL be ignored.
REQ-021 The mode bit SHALL be sampled with its block at input transfer; mode changes SHALL never alter a held result.
REQ-022 blk_count SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 16'h0000.
REQ-023 out_valid SHALL depend only on state, never combinationally on in_valid.

Reset
REQ-024 Reset SHALL force state EMPTY, out_valid=0, out_data=0, and blk_count=0 at the next rising edge.
REQ-025 Reset asserted while FULL SHALL discard the held block without an output transfer and without a blk_count increment.
REQ-026 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-027 Macro SHIFT_ROWS_INV_EN defined: in_inv=1 SHALL select the inverse shift per REQ-013.
REQ-028 Macro SHIFT_ROWS_INV_EN undefined: in_inv SHALL be ignored, forward shift only, and no inverse mux logic SHALL be synthesized.

Verification
REQ-029 NB=4, forward, in_data=d42711aee0bf98f1b8b45de51e415230 -> next cycle out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_valid=1.
REQ-030 NB=4, SHIFT_ROWS_INV_EN, in_inv=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230.
REQ-031 NB=8, forward, in_data bytes 00..1f in order -> row 2 column 0 = byte 0x0e (in(2,3)); row 3 column 0 = byte 0x13 (in(3,4)).
REQ-032 Back-to-back: 3 blocks on consecutive cycles, out_ready=1 -> 3 results on consecutive cycles, blk_count=3, in_ready never low.
REQ-033 Backpressure: FULL, out_ready=0 for 5 cycles with a new in_valid -> in_ready=0, out_data unchanged, the new block accepted in the cycle out_ready rises.
REQ-034 Reset while FULL -> out_valid=0, out_data=0, blk_count=0; with 16'hFFFF preloaded via 65535 transfers, one more transfer -> blk_count=0.

Source files
------------

// File: rtl/shift_rows_stage.sv
// One-entry registered ShiftRows stage with valid/ready handshake on both sides.
// Optional inverse shift (in_inv) is built only when SHIFT_ROWS_INV_EN is defined.

module shift_rows_row #(
    parameter int NB = 4,
    parameter int SH = 0
) (
    input  logic [NB-1:0][7:0] row_in,
`ifdef SHIFT_ROWS_INV_EN
    input  logic               inv,
`endif
    output logic [NB-1:0][7:0] row_out
);

    genvar c;
    generate
        for (c = 0; c < NB; c++) begin : g_col
            localparam int FWD_SRC = (c + SH) % NB;
`ifdef SHIFT_ROWS_INV_EN
            localparam int INV_SRC = (c + NB - SH) % NB;
            assign row_out[c] = inv ? row_in[INV_SRC] : row_in[FWD_SRC];
`else
            assign row_out[c] = row_in[FWD_SRC];
`endif
        end
    endgenerate

endmodule

module shift_rows_stage #(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [15:0]  blk_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q, state_d;
    logic   load;

    logic [3:0][NB-1:0][7:0] rows_in;
    logic [3:0][NB-1:0][7:0] rows_out;
    logic [W-1:0]            shifted;

`ifndef SHIFT_ROWS_INV_EN
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    // Column-major byte order: byte (r,c) sits at byte index 4c+r from the MSB.
    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            for (c = 0; c < NB; c++) begin : g_map
                assign rows_in[r][c]                    = in_data[W-1-8*(4*c+r) -: 8];
                assign shifted[W-1-8*(4*c+r) -: 8]       = rows_out[r][c];
            end

            // Wide (NB=8) states skip offset 2: rows 2 and 3 rotate by 3 and 4.
            localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;

            shift_rows_row #(.NB(NB), .SH(SH)) u_row (
                .row_in  (rows_in[r]),
`ifdef SHIFT_ROWS_INV_EN
                .inv     (in_inv),
`endif
                .row_out (rows_out[r])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == EMPTY) || out_ready;
        load     = in_valid && in_ready;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (out_ready && !in_valid) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign out_valid = (state_q == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            out_data  <= '0;
            blk_count <= '0;
        end else begin
            state_q <= state_d;
            if (load)
                out_data <= shifted;
            if (out_valid && out_ready)
                blk_count <= blk_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_shift_rows_stage.sv
// Scoreboard bench for shift_rows_stage: NB=4 main instance plus an NB=8 instance
// for the wide-state offsets.

module tb_shift_rows_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic [15:0]  blk_count;

    logic         in_valid8, in_ready8, out_valid8, out_ready8;
    logic [255:0] in_data8, out_data8;
    logic [15:0]  blk_count8;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [127:0] K_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] K_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`ifdef SHIFT_ROWS_INV_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_rows_stage #(.NB(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .blk_count(blk_count)
    );

    shift_rows_stage #(.NB(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_inv(1'b0), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_data(out_data8), .blk_count(blk_count8)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: byte (r,c) at bits [W-1-8*(4c+r) -: 8] of the low W bits.
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
        logic [255:0] o;
        int w, s, src;
        int ofs[4];
        w = 32 * nb;
        o = '0;
        if (nb == 8) ofs = '{0, 1, 3, 4};
        else         ofs = '{0, 1, 2, 3};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                s   = ofs[r];
                src = inv ? (c - s + nb) % nb : (c + s) % nb;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    logic [127:0] exp_q[$];
    logic [255:0] mon_tmp;

    // Outputs and handshakes are stable at the falling edge; both refer to the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("scb_underflow", 1, 0);
                else                   chk("scb_data", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                mon_tmp = ref_shift({128'd0, in_data}, 4, in_inv && INV_ON);
                exp_q.push_back(mon_tmp[127:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] tmp;
    logic [127:0] held;
    bit           ir_low;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_blk_count", blk_count, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Known forward vector on NB=4, byte ramp on NB=8
        step();
        in_valid = 1'b1; in_data = K_IN; out_ready = 1'b1;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int k = 0; k < 32; k++) in_data8[255-8*k -: 8] = k[7:0];
        step();
        in_valid = 1'b0; in_valid8 = 1'b0;
        @(negedge clk);
        chk("fwd_valid", out_valid, 1);
        chk("fwd_vector", out_data, K_OUT);
        chk("nb8_valid", out_valid8, 1);
        chk("nb8_r2c0", out_data8[255-8*2 -: 8], 8'h0e);
        chk("nb8_r3c0", out_data8[255-8*3 -: 8], 8'h13);
        chk("nb8_full", out_data8, ref_shift(in_data8, 8, 1'b0));
        step();
        @(negedge clk);
        chk("nb8_count", blk_count8, 1);
        chk("nb8_in_ready", in_ready8, 1);

        // Inverse request: inverse vector when built in, otherwise ignored
        in_valid = 1'b1; in_inv = 1'b1; in_data = K_OUT;
        step();
        in_valid = 1'b0; in_inv = 1'b0;
        @(negedge clk);
        tmp = ref_shift({128'd0, K_OUT}, 4, 1'b0);
        if (INV_ON) chk("inv_vector", out_data, K_IN);
        else        chk("inv_ignored", out_data, tmp[127:0]);
        step();

        // Back-to-back after a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        ir_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'($urandom);
            @(negedge clk);
            if (!in_ready) ir_low = 1'b1;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (!in_ready) ir_low = 1'b1;
        step();
        @(negedge clk);
        chk("b2b_count", blk_count, 3);
        chk("b2b_ready_low", ir_low, 0);

        // Backpressure: hold A while B waits, A must not change
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = {4{32'hA5A5_0001}} ^ 128'h0123_4567_89ab_cdef; in_inv = 1'b0;
        tmp = ref_shift({128'd0, in_data}, 4, 1'b0);
        held = tmp[127:0];
        step();
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom}; in_inv = ~in_inv;
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_data", out_data, held);
            chk("bp_hold_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        in_data = 128'hfeed_face_0000_1111_2222_3333_4444_5555; in_inv = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        tmp = ref_shift({128'd0, 128'hfeed_face_0000_1111_2222_3333_4444_5555}, 4, 1'b0);
        @(negedge clk);
        chk("bp_new_block", out_data, tmp[127:0]);
        step();

        // Reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 128'h1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_before_rst", out_valid, 1);
        step();
        reset = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_full_valid", out_valid, 0);
        chk("rst_full_data", out_data, 0);
        chk("rst_full_count", blk_count, 0);
        step();

        // Counter wrap
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = {4{i[31:0]}};
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("cnt_ffff", blk_count, 16'hffff);
        in_valid = 1'b1; in_data = 128'h5;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("cnt_wrap", blk_count, 16'h0000);
        chk("scb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
